// File: rtl/uart_frame_loader.sv
// UART receiver that pairs bytes into 16-bit words and streams them to an SDRAM write port.
// Optional even-parity bit enabled by defining UART_FRAME_LOADER_PARITY_EN.
module uart_frame_loader #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int FRAME_WORDS = 480000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_pin,
  input  logic        wr_wait,
  input  logic        ovf_clr,
  output logic        wr_req,
  output logic [21:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err,
  output logic        parity_err,
  output logic        frame_done,
  output logic        overflow
);

  localparam int          DIV       = CLK_HZ / (BAUD * 16);
  localparam logic [15:0] DIV_LAST  = (DIV > 1) ? 16'(DIV - 1) : 16'd0;
  localparam logic [21:0] ADDR_LAST = 22'(FRAME_WORDS - 1);

`ifdef UART_FRAME_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4, S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4
  } state_t;
`endif

  logic        rx_meta, rx_sync;
  logic [15:0] div_cnt;
  logic        tick;
  state_t      state, state_n;
  logic [3:0]  tick_cnt, tick_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par_bad, par_bad_n;
  logic        good_byte, bad_frame, bad_parity;

  logic        have_low;
  logic [7:0]  low_byte;
  logic        push, pop, full, accept, drop;
  logic [15:0] push_word;
  logic [15:0] mem [4];
  logic [15:0] mem_n [4];
  logic [1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [2:0]  count, count_n;
  logic [15:0] wr_data_n;
  logic        wr_req_n;

  // Two-flop synchronizer on the asynchronous serial line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
    end
  end

  // Free-running 16x oversample tick generator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 16'd0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 16'd0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
      tick    <= 1'b0;
    end
  end

  // Receiver FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      par_bad  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_bad  <= par_bad_n;
    end
  end

  // Receiver FSM next state; samples land on tick 7 of the start bit, then every 16 ticks
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_bad_n  = par_bad;
    good_byte  = 1'b0;
    bad_frame  = 1'b0;
    bad_parity = 1'b0;
    case (state)
      S_IDLE: begin
        tick_cnt_n = 4'd0;
        bit_cnt_n  = 3'd0;
        par_bad_n  = 1'b0;
        if (!rx_sync) begin
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (tick && (tick_cnt == 4'd7)) begin
          tick_cnt_n = 4'd0;
          state_n    = rx_sync ? S_IDLE : S_DATA;
        end else if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
        end else begin
          tick_cnt_n = tick_cnt;
        end
      end
      S_DATA: begin
        if (tick && (tick_cnt == 4'd15)) begin
          tick_cnt_n = 4'd0;
          shift_n    = {rx_sync, shift[7:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_FRAME_LOADER_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            state_n = S_DATA;
          end
        end else if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
        end else begin
          tick_cnt_n = tick_cnt;
        end
      end
`ifdef UART_FRAME_LOADER_PARITY_EN
      S_PARITY: begin
        if (tick && (tick_cnt == 4'd15)) begin
          tick_cnt_n = 4'd0;
          par_bad_n  = (rx_sync != (^shift));
          bad_parity = (rx_sync != (^shift));
          state_n    = S_STOP;
        end else if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
        end else begin
          tick_cnt_n = tick_cnt;
        end
      end
`endif
      S_STOP: begin
        if (tick && (tick_cnt == 4'd15)) begin
          tick_cnt_n = 4'd0;
          if (rx_sync) begin
            good_byte = !par_bad;
            state_n   = S_IDLE;
          end else begin
            bad_frame = 1'b1;
            state_n   = S_BREAK;
          end
        end else if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
        end else begin
          tick_cnt_n = tick_cnt;
        end
      end
      S_BREAK: begin
        if (rx_sync) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_BREAK;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Registered byte strobes and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= good_byte;
      if (good_byte) begin
        byte_data <= shift;
      end else begin
        byte_data <= byte_data;
      end
      frame_err <= bad_frame;
`ifdef UART_FRAME_LOADER_PARITY_EN
      parity_err <= bad_parity;
`else
      parity_err <= 1'b0;
`endif
    end
  end

  // Byte pairing; any receive error drops a pending low byte so pairing realigns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_low <= 1'b0;
      low_byte <= 8'd0;
    end else if (byte_valid) begin
      have_low <= !have_low;
      low_byte <= have_low ? low_byte : byte_data;
    end else if (frame_err || parity_err) begin
      have_low <= 1'b0;
    end else begin
      have_low <= have_low;
    end
  end

  assign push      = byte_valid && have_low;
  assign push_word = {byte_data, low_byte};
  assign pop       = wr_req && !wr_wait;
  assign full      = (count == 3'd4);
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  // FIFO next state; the head is precomputed so wr_data leaves a flop
  always_comb begin
    mem_n = mem;
    if (accept) begin
      mem_n[wr_ptr] = push_word;
      wr_ptr_n      = wr_ptr + 2'd1;
    end else begin
      wr_ptr_n = wr_ptr;
    end
    if (pop) begin
      rd_ptr_n = rd_ptr + 2'd1;
    end else begin
      rd_ptr_n = rd_ptr;
    end
    case ({accept, pop})
      2'b10:   count_n = count + 3'd1;
      2'b01:   count_n = count - 3'd1;
      default: count_n = count;
    endcase
    wr_data_n = mem_n[rd_ptr_n];
    wr_req_n  = (count_n != 3'd0);
  end

  // FIFO storage, pointers and write-port outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 16'd0;
      end
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      wr_req  <= 1'b0;
      wr_data <= 16'd0;
    end else begin
      mem     <= mem_n;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count   <= count_n;
      wr_req  <= wr_req_n;
      wr_data <= wr_data_n;
    end
  end

  // Frame address counter with end-of-frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr    <= 22'd0;
      frame_done <= 1'b0;
    end else if (pop && (wr_addr == ADDR_LAST)) begin
      wr_addr    <= 22'd0;
      frame_done <= 1'b1;
    end else if (pop) begin
      wr_addr    <= wr_addr + 22'd1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
    end
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized self-checking bench for uart_frame_loader against a queue-based byte/word model.
module tb_uart_frame_loader;

  localparam int CLK_HZ = 5529600;
  localparam int BAUD   = 115200;
  localparam int FW     = 4;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = DIV * 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        wr_wait = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err, parity_err, frame_done, overflow;

  uart_frame_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_pin(rx_pin), .wr_wait(wr_wait), .ovf_clr(ovf_clr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .byte_valid(byte_valid),
    .byte_data(byte_data), .frame_err(frame_err), .parity_err(parity_err),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]  bq [$];
  logic [15:0] wq [$];
  bit          have_low;
  logic [7:0]  low;
  int          exp_addr, exp_done, exp_ferr;
  bit          exp_ovf;
  int          bv_seen, done_seen, ferr_seen, perr_seen;
  bit          rand_wait = 1'b0;
  bit          prev_stall, last_wrap;
  logic [21:0] prev_addr;
  logic [15:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_pin  = 1'b1;
    ovf_clr = 1'b0;
    bq.delete();
    wq.delete();
    have_low = 1'b0;
    exp_addr = 0;
    exp_ovf  = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
  endtask

  // Model: good bytes pair low/high; a word is kept only while fewer than 4 are pending
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (good) begin
      bq.push_back(b);
      if (have_low) begin
        if (wq.size() < 4) wq.push_back({b, low});
        else exp_ovf = 1'b1;
        have_low = 1'b0;
      end else begin
        low = b;
        have_low = 1'b1;
      end
    end else begin
      exp_ferr++;
      have_low = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    model_byte(b, stop);
    rx_pin = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      cyc(BIT);
    end
`ifdef UART_FRAME_LOADER_PARITY_EN
    rx_pin = ^b;
    cyc(BIT);
`endif
    rx_pin = stop;
    cyc(BIT);
    rx_pin = 1'b1;
    if (!stop) cyc(2 * BIT);
    cyc(4);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_wait) wr_wait = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: bytes, transfers, stall stability and frame_done alignment against the model
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      last_wrap  = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_req", wr_req, 1);
        check_eq("stall_addr", wr_addr, prev_addr);
        check_eq("stall_data", wr_data, prev_data);
      end
      if (byte_valid) begin
        bv_seen++;
        check_eq("byte_expected", (bq.size() != 0), 1);
        if (bq.size() != 0) check_eq("byte_data", byte_data, bq.pop_front());
      end
      if (frame_err) ferr_seen++;
      if (parity_err) perr_seen++;
      if (frame_done) begin
        done_seen++;
        check_eq("done_align", last_wrap, 1);
      end
      last_wrap = 1'b0;
      if (wr_req && !wr_wait) begin
        check_eq("xfer_expected", (wq.size() != 0), 1);
        if (wq.size() != 0) check_eq("xfer_data", wr_data, wq.pop_front());
        check_eq("xfer_addr", wr_addr, exp_addr);
        last_wrap = (wr_addr == 22'(FW - 1));
        if (exp_addr == FW - 1) begin
          exp_addr = 0;
          exp_done++;
        end else begin
          exp_addr++;
        end
      end
      prev_stall = wr_req && wr_wait;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  initial begin
    int bv_before;
    do_reset();
    check_eq("rst_wr_req", wr_req, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_byte_data", byte_data, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_pulses", {byte_valid, frame_err, parity_err, frame_done}, 0);

    // Single byte
    send_byte(8'h55, 1'b1);
    cyc(BIT);
    check_eq("b55_data", byte_data, 8'h55);
    check_eq("b55_ferr", ferr_seen, exp_ferr);

    // Word pairing
    do_reset();
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    cyc(20);
    check_eq("pair_wr_req", wr_req, 0);
    check_eq("pair_words_left", wq.size(), 0);
    check_eq("pair_addr_next", wr_addr, 1);

    // Start-bit glitch rejected
    bv_before = bv_seen;
    rx_pin = 1'b0;
    cyc(4 * DIV);
    rx_pin = 1'b1;
    cyc(3 * BIT);
    check_eq("glitch_no_byte", bv_seen, bv_before);
    send_byte(8'h55, 1'b1);
    check_eq("glitch_recover", byte_data, 8'h55);

    // Framing error then recovery
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b1);
    check_eq("ferr_count", ferr_seen, exp_ferr);
    check_eq("ferr_next_byte", byte_data, 8'h3C);

    // Overflow under stall
    do_reset();
    wr_wait = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'(($urandom & 32'hFF)), 1'b1);
    cyc(10);
    check_eq("ovf_set", overflow, exp_ovf);
    check_eq("ovf_queued", wr_req, 1);
    wr_wait = 1'b0;
    cyc(20);
    check_eq("ovf_drained", wq.size(), 0);
    check_eq("ovf_held", overflow, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
    check_eq("ovf_cleared", overflow, 0);

    // Frame wrap
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(8'(($urandom & 32'hFF)), 1'b1);
    cyc(20);
    check_eq("wrap_words_left", wq.size(), 0);
    check_eq("wrap_done_count", done_seen, exp_done);
    check_eq("wrap_addr_after", wr_addr, exp_addr);

    // Reset in the middle of a byte
    rx_pin = 1'b0;
    cyc(BIT);
    rx_pin = 1'b0;
    cyc(BIT / 2);
    do_reset();
    send_byte(8'h0F, 1'b1);
    check_eq("midrst_byte", byte_data, 8'h0F);
    check_eq("midrst_no_word", wr_req, 0);

    // Randomized traffic with random stalls and occasional framing errors
    rand_wait = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_byte(8'(($urandom & 32'hFF)), ($urandom_range(0, 5) != 0));
      cyc($urandom_range(0, 30));
    end
    cyc(40);
    rand_wait = 1'b0;
    wr_wait = 1'b0;
    cyc(10);

    check_eq("end_bytes_left", bq.size(), 0);
    check_eq("end_words_left", wq.size(), 0);
    check_eq("end_ferr_count", ferr_seen, exp_ferr);
    check_eq("end_done_count", done_seen, exp_done);
    check_eq("end_addr", wr_addr, exp_addr);
`ifndef UART_FRAME_LOADER_PARITY_EN
    check_eq("end_no_parity_err", perr_seen, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
